// File: rtl/led_status_conditioner.sv
//-----------------------------------------------------------------------------
// led_status_conditioner
//
// Conditions the raw status flags that feed the front-panel LED logic.
//   - Every asynchronous input passes through a SYNC_STAGES-deep synchroniser.
//   - Aurora channel-up is debounced on its rising edge by a DOWN/PEND/UP FSM.
//     The falling edge is not debounced, and every UP->DOWN transition counts
//     as a link drop.
//   - Each state-machine idle flag is stretched. A busy (idle=0) holds the
//     output low for HOLD_CYCLES cycles after the busy ends, so short bursts of
//     activity stay visible on the LED.
//
// Ports:
//   clk                         in   block clock
//   rst                         in   asynchronous active-high reset
//   aurora_channel_up_in        in   raw channel-up (async)
//   adc_acq_sm_idle_in          in   raw ADC acquisition SM idle (async)
//   command_sm_idle_in          in   raw command SM idle (async)
//   ddr3_wr_control_sm_idle_in  in   raw DDR3 write-control SM idle (async)
//   link_drop_cnt_clr           in   synchronous clear of link_drop_cnt
//   aurora_channel_up           out  debounced channel-up
//   adc_acq_sm_idle             out  stretched idle
//   command_sm_idle             out  stretched idle
//   ddr3_wr_control_sm_idle     out  stretched idle
//   link_drop_cnt[7:0]          out  saturating count of link drops
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module led_status_conditioner #(
    parameter int SYNC_STAGES   = 2,
    parameter int GLITCH_CYCLES = 16,
    parameter int HOLD_CYCLES   = 12500000,
    parameter int HOLD_W        = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       aurora_channel_up_in,
    input  logic       adc_acq_sm_idle_in,
    input  logic       command_sm_idle_in,
    input  logic       ddr3_wr_control_sm_idle_in,
    input  logic       link_drop_cnt_clr,
    output logic       aurora_channel_up,
    output logic       adc_acq_sm_idle,
    output logic       command_sm_idle,
    output logic       ddr3_wr_control_sm_idle,
    output logic [7:0] link_drop_cnt
);

    localparam int GW = $clog2(GLITCH_CYCLES + 1);
    localparam logic [GW-1:0]     GLITCH_MAX = GW'(GLITCH_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        ST_DOWN = 2'd0,
        ST_PEND = 2'd1,
        ST_UP   = 2'd2
    } cu_state_t;

    logic [SYNC_STAGES-1:0] r_cu_sync;
    logic                   w_cu_synced;
    cu_state_t              r_state;
    logic [GW-1:0]          r_glitch_cnt;
    logic                   r_cu_up;
    logic                   w_drop;
    logic [7:0]             r_drop_cnt;
    logic [2:0]             w_idle_raw;

    assign w_idle_raw  = {ddr3_wr_control_sm_idle_in, command_sm_idle_in, adc_acq_sm_idle_in};
    assign w_cu_synced = r_cu_sync[SYNC_STAGES-1];
    // A drop is the UP->DOWN transition happening on this edge.
    assign w_drop      = (r_state == ST_UP) && !w_cu_synced;

    // Channel-up synchroniser; resets to "down".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cu_sync <= '0;
        end else begin
            r_cu_sync <= {r_cu_sync[SYNC_STAGES-2:0], aurora_channel_up_in};
        end
    end

    // Channel-up debounce FSM. The output is registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_DOWN;
            r_glitch_cnt <= '0;
            r_cu_up      <= 1'b0;
        end else begin
            case (r_state)
                ST_DOWN: begin
                    if (w_cu_synced) begin
                        r_state      <= ST_PEND;
                        r_glitch_cnt <= GW'(1);
                    end else begin
                        r_state      <= ST_DOWN;
                        r_glitch_cnt <= '0;
                    end
                    r_cu_up <= 1'b0;
                end
                ST_PEND: begin
                    if (!w_cu_synced) begin
                        r_state      <= ST_DOWN;
                        r_glitch_cnt <= '0;
                        r_cu_up      <= 1'b0;
                    end else if (r_glitch_cnt == GLITCH_MAX) begin
                        r_state      <= ST_UP;
                        r_glitch_cnt <= '0;
                        r_cu_up      <= 1'b1;
                    end else begin
                        r_state      <= ST_PEND;
                        r_glitch_cnt <= r_glitch_cnt + GW'(1);
                        r_cu_up      <= 1'b0;
                    end
                end
                ST_UP: begin
                    // The falling edge is taken immediately, with no debounce.
                    if (!w_cu_synced) begin
                        r_state <= ST_DOWN;
                        r_cu_up <= 1'b0;
                    end else begin
                        r_state <= ST_UP;
                        r_cu_up <= 1'b1;
                    end
                    r_glitch_cnt <= '0;
                end
                default: begin
                    r_state      <= ST_DOWN;
                    r_glitch_cnt <= '0;
                    r_cu_up      <= 1'b0;
                end
            endcase
        end
    end

    // Link-drop counter. A clear wins over the old value, but a drop on the
    // same edge is still counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= 8'd0;
        end else if (link_drop_cnt_clr) begin
            r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end else begin
            r_drop_cnt <= r_drop_cnt;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_stretch
        logic [SYNC_STAGES-1:0] r_sync;
        logic [HOLD_W-1:0]      r_hc;
        logic                   r_idle;

        // Idle synchroniser; resets to "idle".
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync <= '1;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_idle_raw[g]};
            end
        end

        // Busy stretcher. Any busy reloads the hold counter, so the stretch
        // restarts from the most recent busy.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_hc   <= '0;
                r_idle <= 1'b1;
            end else if (!r_sync[SYNC_STAGES-1]) begin
                r_hc   <= HOLD_LOAD;
                r_idle <= 1'b0;
            end else if (r_hc != '0) begin
                r_hc   <= r_hc - HOLD_W'(1);
                r_idle <= 1'b0;
            end else begin
                r_hc   <= r_hc;
                r_idle <= 1'b1;
            end
        end
    end

    assign aurora_channel_up       = r_cu_up;
    assign adc_acq_sm_idle         = g_stretch[0].r_idle;
    assign command_sm_idle         = g_stretch[1].r_idle;
    assign ddr3_wr_control_sm_idle = g_stretch[2].r_idle;
    assign link_drop_cnt           = r_drop_cnt;

endmodule

// File: tb/tb_led_status_conditioner.sv
`timescale 1ns/1ps
module tb_led_status_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cu_in = 1'b0, adc_in = 1'b1, cmd_in = 1'b1, ddr_in = 1'b1, clr = 1'b0;
    logic       cu_out, adc_out, cmd_out, ddr_out;
    logic [7:0] cnt_out;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt = 0;

    // Scoreboard entry: signal id must equal val at the negedge when cyc == due.
    // ids: 0 channel_up, 1 adc idle, 2 cmd idle, 3 ddr idle, 4 drop count
    typedef struct {
        int due;
        int id;
        int val;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int kind;   // 0: channel-up pulse, 1: busy pulse on idle channels
        int mask;   // idle channel mask (bit0 adc, bit1 cmd, bit2 ddr)
        int len;    // pulse length in cycles
        int exp;    // kind 0: 1 if UP is expected
    } vec_t;

    string names [5] = '{"aurora_channel_up", "adc_acq_sm_idle", "command_sm_idle",
                         "ddr3_wr_control_sm_idle", "link_drop_cnt"};

    led_status_conditioner #(
        .SYNC_STAGES(2), .GLITCH_CYCLES(4), .HOLD_CYCLES(8), .HOLD_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .aurora_channel_up_in(cu_in),
        .adc_acq_sm_idle_in(adc_in),
        .command_sm_idle_in(cmd_in),
        .ddr3_wr_control_sm_idle_in(ddr_in),
        .link_drop_cnt_clr(clr),
        .aurora_channel_up(cu_out),
        .adc_acq_sm_idle(adc_out),
        .command_sm_idle(cmd_out),
        .ddr3_wr_control_sm_idle(ddr_out),
        .link_drop_cnt(cnt_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sig_val(int id);
        case (id)
            0: return int'(cu_out);
            1: return int'(adc_out);
            2: return int'(cmd_out);
            3: return int'(ddr_out);
            default: return int'(cnt_out);
        endcase
    endfunction

    task automatic check(string nm, int act, int exp, int at);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", nm, at, act, exp);
        end
    endtask

    task automatic expect_span(int id, int from, int to, int val);
        for (int k = from; k <= to; k++) begin
            exp_t e;
            e.due = k; e.id = id; e.val = val;
            sb.push_back(e);
        end
    endtask

    task automatic ticks(int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard consumer: compares every entry that falls due this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check(names[sb[i].id], sig_val(sb[i].id), sb[i].val, cyc);
                sb.delete(i);
            end
        end
    end

    initial begin
        vec_t vecs [8];
        int   t0;
        vecs[0] = '{0, 0, 3, 0};
        vecs[1] = '{0, 0, 4, 0};   // synced run of exactly GLITCH_CYCLES: no UP
        vecs[2] = '{0, 0, 5, 1};
        vecs[3] = '{0, 0, 10, 1};
        vecs[4] = '{1, 2, 1, 0};
        vecs[5] = '{1, 1, 1, 0};
        vecs[6] = '{1, 4, 3, 0};
        vecs[7] = '{1, 7, 2, 0};

        // Reset values while reset is held
        ticks(3);
        #1;
        for (int id = 0; id < 5; id++) check({"reset_", names[id]}, sig_val(id), (id >= 1 && id <= 3) ? 1 : 0, cyc);

        // Release and confirm nothing moves for 20 cycles
        @(negedge clk);
        rst = 1'b0;
        t0 = cyc;
        expect_span(0, t0 + 1, t0 + 20, 0);
        for (int id = 1; id < 4; id++) expect_span(id, t0 + 1, t0 + 20, 1);
        expect_span(4, t0 + 1, t0 + 20, 0);
        ticks(22);

        // Table-driven single events
        for (int v = 0; v < 8; v++) begin
            int len;
            len = vecs[v].len;
            @(negedge clk);
            t0 = cyc;
            if (vecs[v].kind == 0) begin
                cu_in = 1'b1;
                if (vecs[v].exp != 0) begin
                    expect_span(0, t0 + 1, t0 + 6, 0);
                    expect_span(0, t0 + 7, t0 + len + 2, 1);
                    expect_span(0, t0 + len + 3, t0 + len + 4, 0);
                    expect_span(4, t0 + 1, t0 + len + 2, exp_cnt);
                    exp_cnt++;
                    expect_span(4, t0 + len + 3, t0 + len + 6, exp_cnt);
                end else begin
                    expect_span(0, t0 + 1, t0 + len + 8, 0);
                    expect_span(4, t0 + 1, t0 + len + 8, exp_cnt);
                end
                ticks(len);
                cu_in = 1'b0;
                ticks(12);
            end else begin
                adc_in = ((vecs[v].mask >> 0) & 1) == 0;
                cmd_in = ((vecs[v].mask >> 1) & 1) == 0;
                ddr_in = ((vecs[v].mask >> 2) & 1) == 0;
                for (int c = 0; c < 3; c++) begin
                    if (((vecs[v].mask >> c) & 1) != 0) begin
                        expect_span(c + 1, t0 + 1, t0 + 2, 1);
                        expect_span(c + 1, t0 + 3, t0 + len + 10, 0);
                        expect_span(c + 1, t0 + len + 11, t0 + len + 12, 1);
                    end else begin
                        expect_span(c + 1, t0 + 1, t0 + len + 12, 1);
                    end
                end
                expect_span(0, t0 + 1, t0 + len + 12, 0);
                ticks(len);
                adc_in = 1'b1; cmd_in = 1'b1; ddr_in = 1'b1;
                ticks(14);
            end
        end

        // Two command busies 5 cycles apart: one continuous low stretch
        @(negedge clk);
        t0 = cyc;
        cmd_in = 1'b0;
        expect_span(2, t0 + 1, t0 + 2, 1);
        expect_span(2, t0 + 3, t0 + 16, 0);
        expect_span(2, t0 + 17, t0 + 18, 1);
        ticks(1); cmd_in = 1'b1;
        ticks(4); cmd_in = 1'b0;
        ticks(1); cmd_in = 1'b1;
        ticks(14);

        // Channel up, 2-cycle drop, re-rise
        @(negedge clk);
        t0 = cyc;
        cu_in = 1'b1;
        expect_span(0, t0 + 6, t0 + 6, 0);
        expect_span(0, t0 + 7, t0 + 10, 1);
        ticks(10);
        t0 = cyc;
        cu_in = 1'b0;
        expect_span(0, t0 + 1, t0 + 2, 1);
        expect_span(0, t0 + 3, t0 + 8, 0);
        expect_span(0, t0 + 9, t0 + 12, 1);
        expect_span(4, t0 + 2, t0 + 2, exp_cnt);
        exp_cnt++;
        expect_span(4, t0 + 3, t0 + 4, exp_cnt);
        ticks(2);
        cu_in = 1'b1;
        ticks(10);

        // 256 drops: count saturates at 255
        for (int k = 1; k <= 256; k++) begin
            t0 = cyc;
            cu_in = 1'b1;
            expect_span(0, t0 + 7, t0 + 7, 1);
            expect_span(4, t0 + 8, t0 + 8, (exp_cnt + k > 255) ? 255 : exp_cnt + k);
            ticks(5);
            cu_in = 1'b0;
            ticks(2);
        end

        // Clear coinciding with a drop while saturated -> 1, then clear alone -> 0
        cu_in = 1'b1;
        ticks(10);
        t0 = cyc;
        cu_in = 1'b0;
        expect_span(4, t0 + 1, t0 + 2, 255);
        expect_span(4, t0 + 3, t0 + 6, 1);
        expect_span(0, t0 + 2, t0 + 2, 1);
        expect_span(0, t0 + 3, t0 + 3, 0);
        ticks(2);
        clr = 1'b1;
        ticks(1);
        clr = 1'b0;
        ticks(4);
        t0 = cyc;
        clr = 1'b1;
        expect_span(4, t0 + 1, t0 + 2, 0);
        ticks(1);
        clr = 1'b0;
        ticks(20);

        // Reset mid-stretch and mid-PEND
        t0 = cyc;
        adc_in = 1'b0;
        cu_in = 1'b1;
        expect_span(1, t0 + 3, t0 + 3, 0);
        ticks(1);
        adc_in = 1'b1;
        ticks(3);
        rst = 1'b1;
        #1;
        check("reset_mid_adc_idle", int'(adc_out), 1, cyc);
        check("reset_mid_channel_up", int'(cu_out), 0, cyc);
        check("reset_mid_cmd_idle", int'(cmd_out), 1, cyc);
        check("reset_mid_drop_cnt", int'(cnt_out), 0, cyc);
        ticks(2);
        rst = 1'b0;
        t0 = cyc;
        expect_span(0, t0 + 1, t0 + 6, 0);
        expect_span(0, t0 + 7, t0 + 9, 1);
        expect_span(1, t0 + 1, t0 + 10, 1);
        expect_span(4, t0 + 1, t0 + 9, 0);
        ticks(12);

        ticks(5);
        #1;
        foreach (sb[i]) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: expectation for cycle %0d never compared (expected %0d)", names[sb[i].id], sb[i].due, sb[i].val);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/led_status_conditioner.md
# led_status_conditioner

Conditions the raw status flags feeding the front-panel LED logic. It synchronises each asynchronous status input into the `clk` domain and debounces the Aurora channel-up flag. It stretches every state-machine busy indication so that short activity bursts stay visible on the LED, and counts link drops. Its outputs drive the LED status block's `aurora_channel_up`, `adc_acq_sm_idle`, `command_sm_idle` and `ddr3_wr_control_sm_idle` inputs directly.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth per input, minimum 2.
- `GLITCH_CYCLES`, default 16: consecutive synced-high cycles before channel-up is accepted, minimum 1.
- `HOLD_CYCLES`, default 12500000: busy-stretch length in `clk` cycles (100 ms at 125 MHz), minimum 1.
- `HOLD_W`, default 24: hold counter width; must satisfy 2^HOLD_W > HOLD_CYCLES.

Ports:
- `clk`, input, 1: the block's only clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `aurora_channel_up_in`, input, 1: raw channel-up, asynchronous.
- `adc_acq_sm_idle_in`, input, 1: raw ADC acquisition SM idle, asynchronous.
- `command_sm_idle_in`, input, 1: raw command SM idle, asynchronous.
- `ddr3_wr_control_sm_idle_in`, input, 1: raw DDR3 write-control SM idle, asynchronous.
- `link_drop_cnt_clr`, input, 1: synchronous clear of `link_drop_cnt`.
- `aurora_channel_up`, output, 1: debounced channel-up.
- `adc_acq_sm_idle`, output, 1: stretched idle.
- `command_sm_idle`, output, 1: stretched idle.
- `ddr3_wr_control_sm_idle`, output, 1: stretched idle.
- `link_drop_cnt`, output, 8: saturating count of accepted link drops.

## Operation
- Every output is registered.
- Reset values: `aurora_channel_up`=0, all three idle outputs=1, `link_drop_cnt`=0.
- Synchroniser reset values: the channel-up chain resets to 0; the idle chains reset to 1.
- Synchroniser: each input passes through a chain of SYNC_STAGES flops. The last stage is the "synced" value.
- Channel-up FSM, states DOWN, PEND, UP. Reset state is DOWN. Output is 1 only in UP.
  - DOWN: synced=1 -> PEND, with glitch counter set to 1.
  - PEND: synced=0 -> DOWN, with the counter cleared.
  - PEND: synced=1 and counter==GLITCH_CYCLES -> UP.
  - PEND: synced=1 and counter below GLITCH_CYCLES -> counter increments.
  - UP: synced=0 -> DOWN immediately, with no debounce on the falling edge.
- Drop counter:
  - Increments by 1 on every UP->DOWN transition and saturates at 255. PEND->DOWN is not a drop.
  - Clear has priority over the old value. Clear and drop in the same cycle leave the count at 1.
  - Clear while the count is saturated leaves it at 0, or 1 if a drop coincides.
- Busy stretcher, three independent identical instances, each with a HOLD_W-bit counter `hc`:
  - When synced idle=0: load `hc`=HOLD_CYCLES and drive the output to 0.
  - When synced idle=1 and `hc`>0: decrement `hc`; the output stays 0.
  - When synced idle=1 and `hc`==0: the output is 1.
  - A new busy while stretching reloads `hc`, so the stretch restarts.
- All four channels are independent. Simultaneous events on different channels do not interact.
- Reset asserted mid-operation immediately forces the reset values, clears all counters and puts the FSM in DOWN. After release, behaviour is as from power-up.

## Timing
- Input-to-synced latency: SYNC_STAGES cycles. Output register: +1 cycle.
- Idle falling edge (busy) appears on the output SYNC_STAGES+1 cycles after the input edge is first sampled.
- Idle rising edge appears on the output SYNC_STAGES+1+HOLD_CYCLES cycles after the input edge is sampled, provided no further busy occurs.
- A 1-cycle busy at the synced point gives an output low for exactly 1+HOLD_CYCLES cycles.
- Channel-up rising edge: the output rises SYNC_STAGES+GLITCH_CYCLES+1 cycles after the input rises, provided the input stays high throughout.
  - A synced high run of at most GLITCH_CYCLES cycles never produces UP.
- Channel-up falling edge: the output falls SYNC_STAGES+1 cycles after the input falls.
  - `link_drop_cnt` updates on the same clock edge as the output fall.
- `link_drop_cnt_clr` takes effect on the next clock edge.
- Inputs are treated as fully asynchronous. A single-cycle pulse narrower than one `clk` period may be missed, and this is acceptable.

## Test plan
Bench parameters: SYNC_STAGES=2, GLITCH_CYCLES=4, HOLD_CYCLES=8, HOLD_W=4.
- Reset release with all inputs idle/down -> outputs `aurora_channel_up`=0, idles=1, `link_drop_cnt`=0, with no change for 20 cycles.
- `aurora_channel_up_in` high for 3 cycles, then low -> the output stays 0 and the count stays 0. Input then held high -> output rises exactly 7 cycles after the rise is sampled.
- With the channel UP, input low for 2 cycles, then high -> output falls 3 cycles after the fall and `link_drop_cnt`=1. Output returns to 1 after the debounce: 7 cycles after the re-rise.
- `command_sm_idle_in` low for 1 cycle -> output low for 9 cycles starting 3 cycles later. A second 1-cycle busy 5 cycles after the first -> output stays low continuously until 9 cycles after the second.
- 256 drop events -> `link_drop_cnt` saturates at 255. Clear asserted in the same cycle as a further drop -> count=1.
- Reset asserted mid-stretch and mid-PEND -> idle outputs=1 and channel-up=0 immediately. After release, a fresh channel-up requires the full 7-cycle latency.
